// File: rtl/calendar_pkg.sv
// ---------------------------------------------------------------------------
// calendar_pkg
// Shared constants for the calendar time-set logic: the field ordering used
// by the one-hot field buses, the number of editable fields, and the
// sequencer state encoding.
// ---------------------------------------------------------------------------
package calendar_pkg;

  localparam int NUM_FIELDS = 5;

  localparam int FLD_MIN   = 0;
  localparam int FLD_HOUR  = 1;
  localparam int FLD_DAY   = 2;
  localparam int FLD_MONTH = 3;
  localparam int FLD_YEAR  = 4;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } state_t;

endpackage

// File: rtl/calendar_key_cond.sv
// ---------------------------------------------------------------------------
// calendar_key_cond
// Conditions one raw active-low push button. It synchronises the pin,
// detects the press (falling) edge and, when REPEAT_EN is set, adds
// auto-repeat pulses while the key stays held.
//
// Ports
//   clock   in   system clock
//   reset   in   asynchronous, active-high reset
//   key_n   in   raw button pin, active-low
//   clear   in   1 = drop any repeat in progress; the held key must be
//                released and pressed again before it repeats
//   press   out  1-cycle pulse on a press edge or an auto-repeat tick
// ---------------------------------------------------------------------------
module calendar_key_cond #(
  parameter bit REPEAT_EN    = 1'b0,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000,
  parameter int CNT_BITS     = 25
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  input  logic clear,
  output logic press
);

  logic                sync_1;
  logic                sync_2;
  logic                sync_prev;
  logic                armed;
  logic                in_rate;
  logic [CNT_BITS-1:0] rpt_cnt;
  logic                held;
  logic                fall;
  logic                at_limit;

  // Two-stage synchroniser plus one delay stage for edge detection. All
  // stages come out of reset as "released" so that releasing reset never
  // looks like a press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_1    <= 1'b1;
      sync_2    <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync_1    <= key_n;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
    end
  end

  assign held     = ~sync_2;
  assign fall     = sync_prev & ~sync_2;
  assign at_limit = in_rate ? (rpt_cnt == CNT_BITS'(REPEAT_RATE - 1))
                            : (rpt_cnt == CNT_BITS'(REPEAT_DELAY - 1));

  // Repeat timer. A press edge arms it; the first tick comes after the long
  // delay and later ticks after the shorter rate. Release or clear disarms,
  // and clear wins over a press edge in the same cycle so that a key still
  // held afterwards stays quiet until it is pressed again.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armed   <= 1'b0;
      in_rate <= 1'b0;
      rpt_cnt <= '0;
    end else if (clear || !held) begin
      armed   <= 1'b0;
      in_rate <= 1'b0;
      rpt_cnt <= '0;
    end else if (fall) begin
      armed   <= 1'b1;
      in_rate <= 1'b0;
      rpt_cnt <= '0;
    end else if (armed) begin
      if (at_limit) begin
        rpt_cnt <= '0;
        in_rate <= 1'b1;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end

  assign press = fall | (REPEAT_EN & armed & held & ~clear & at_limit);

endmodule

// File: rtl/calendar_set_controller.sv
// ---------------------------------------------------------------------------
// calendar_set_controller
// Time-set sequencer for the calendar. In set mode it walks one editable
// field at a time (MIN, HOUR, DAY, MONTH, YEAR), sends increment pulses to
// the selected field counter, stops the time base and blinks the field
// being edited.
//
// Ports
//   clock       in   system clock
//   reset       in   asynchronous, active-high reset
//   set         in   set-mode switch level, 1 = set mode
//   key_up_n    in   raw increment key, active-low
//   key_mode_n  in   raw next-field key, active-low
//   field_sel   out  one-hot edited field, all 0 while running
//   field_up    out  1-cycle increment pulse to the selected field
//   run_en      out  1 = time base advances
//   sec_clear   out  1-cycle pulse when leaving set mode
//   blank_mask  out  1 = blank that field's digits this cycle
// ---------------------------------------------------------------------------
module calendar_set_controller #(
  parameter int NUM_FIELDS   = calendar_pkg::NUM_FIELDS,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000,
  parameter int BLINK_DIV    = 12500000,
  parameter int CNT_BITS     = 25
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  set,
  input  logic                  key_up_n,
  input  logic                  key_mode_n,
  output logic [NUM_FIELDS-1:0] field_sel,
  output logic [NUM_FIELDS-1:0] field_up,
  output logic                  run_en,
  output logic                  sec_clear,
  output logic [NUM_FIELDS-1:0] blank_mask
);

  import calendar_pkg::state_t;
  import calendar_pkg::ST_RUN;
  import calendar_pkg::ST_SET;
  import calendar_pkg::FLD_MIN;

  localparam int FIELD_BITS = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam logic [FIELD_BITS-1:0] FIRST_FIELD = FIELD_BITS'(FLD_MIN);
  localparam logic [FIELD_BITS-1:0] LAST_FIELD  = FIELD_BITS'(NUM_FIELDS - 1);
  localparam logic [NUM_FIELDS-1:0] ONE_HOT0    = NUM_FIELDS'(1);

  state_t                state;
  state_t                next_state;
  logic [FIELD_BITS-1:0] field_idx;
  logic [FIELD_BITS-1:0] next_field;
  logic [CNT_BITS-1:0]   blink_cnt;
  logic [CNT_BITS-1:0]   next_blink_cnt;
  logic                  blink_phase;
  logic                  next_phase;
  logic                  set_meta;
  logic                  set_sync;
  logic                  up_press;
  logic                  mode_press;
  logic                  up_clear;
  logic                  up_fire;
  logic                  field_change;

  // The up key only repeats while a field is being edited; leaving set
  // mode or moving to another field cancels a repeat in progress.
  assign up_clear = (state != ST_SET) | ~set_sync | mode_press;

  calendar_key_cond #(
    .REPEAT_EN    (1'b1),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE),
    .CNT_BITS     (CNT_BITS)
  ) u_key_up (
    .clock (clock),
    .reset (reset),
    .key_n (key_up_n),
    .clear (up_clear),
    .press (up_press)
  );

  calendar_key_cond #(
    .REPEAT_EN    (1'b0),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE),
    .CNT_BITS     (CNT_BITS)
  ) u_key_mode (
    .clock (clock),
    .reset (reset),
    .key_n (key_mode_n),
    .clear (1'b1),
    .press (mode_press)
  );

  // The set switch is synchronised like the keys but resets to 0, so
  // coming out of reset with the switch already on is seen as a rise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      set_meta <= 1'b0;
      set_sync <= 1'b0;
    end else begin
      set_meta <= set;
      set_sync <= set_meta;
    end
  end

  // Next state, next field and blink timing. Mode beats up when both
  // arrive together. The blink restarts dark-free on entry, on every
  // field change and on every increment, so the digits being adjusted
  // stay visible.
  always_comb begin
    next_state     = state;
    next_field     = field_idx;
    field_change   = 1'b0;
    up_fire        = 1'b0;
    next_blink_cnt = blink_cnt + 1'b1;
    next_phase     = blink_phase;

    case (state)
      ST_RUN: begin
        if (set_sync) begin
          next_state   = ST_SET;
          next_field   = FIRST_FIELD;
          field_change = 1'b1;
        end
      end
      ST_SET: begin
        if (!set_sync) begin
          next_state = ST_RUN;
          next_field = FIRST_FIELD;
        end else if (mode_press) begin
          field_change = 1'b1;
          next_field   = (field_idx == LAST_FIELD) ? FIRST_FIELD
                                                   : field_idx + 1'b1;
        end else if (up_press) begin
          up_fire = 1'b1;
        end
      end
      default: begin
        next_state = ST_RUN;
        next_field = FIRST_FIELD;
      end
    endcase

    if (next_state != ST_SET || field_change || up_fire) begin
      next_blink_cnt = '0;
      next_phase     = 1'b0;
    end else if (blink_cnt == CNT_BITS'(BLINK_DIV - 1)) begin
      next_blink_cnt = '0;
      next_phase     = ~blink_phase;
    end
  end

  // State and output registers. Outputs are built from the next-state
  // values so they line up with the state they describe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      field_idx   <= FIRST_FIELD;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      field_sel   <= '0;
      field_up    <= '0;
      run_en      <= 1'b1;
      sec_clear   <= 1'b0;
      blank_mask  <= '0;
    end else begin
      state       <= next_state;
      field_idx   <= next_field;
      blink_cnt   <= next_blink_cnt;
      blink_phase <= next_phase;
      field_sel   <= (next_state == ST_SET) ? (ONE_HOT0 << next_field) : '0;
      field_up    <= up_fire ? (ONE_HOT0 << field_idx) : '0;
      run_en      <= (next_state == ST_RUN);
      sec_clear   <= (state == ST_SET) && (next_state == ST_RUN);
      blank_mask  <= ((next_state == ST_SET) && next_phase) ?
                     (ONE_HOT0 << next_field) : '0;
    end
  end

endmodule
